pipe_hazard_ctrl: RTL

Hazard interlock and flush controller for the 5-stage MIPS pipeline CPU (IF/ID/EX/MEM/WB, branch resolved in MEM).
- Keeps a shadow scoreboard of the destination registers in flight in the EX, MEM and WB slots.
- Stalls PC and IF/ID, and injects an ID/EX bubble, while an ID-stage source register is pending.
- Flushes wrong-path instructions on a taken branch.
- Keeps saturating stall and flush event counters for the testbench.

---
 rtl/pipe_hazard_ctrl.sv | 92 +++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard interlock and flush controller for a 5-stage MIPS pipeline with branches resolved in MEM.
// Tracks in-flight destination registers, stalls on RAW hazards, flushes on taken branches.
module pipe_hazard_ctrl #(
  parameter int REG_AW    = 5,
  parameter int CNT_W     = 16,
  parameter bit WB_BYPASS = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_use_rs_i,
  input  logic              id_use_rt_i,
  input  logic              id_reg_write_i,
  input  logic [REG_AW-1:0] id_dst_i,
  input  logic              branch_taken_mem_i,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic              ifid_flush_o,
  output logic              idex_flush_o,
  output logic              exmem_flush_o,
  output logic              stall_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] dst;
  } slot_t;

  slot_t ex_q, mem_q, wb_q;
  slot_t ex_d, mem_d;
  logic  raw;

  // A source register is pending if any live slot will still write it back.
  function automatic logic hit(input logic [REG_AW-1:0] r, input slot_t ex, input slot_t mem,
                               input slot_t wb);
    logic wb_hit;
    wb_hit = !WB_BYPASS && wb.v && (wb.dst == r);
    return (r != '0) && ((ex.v && ex.dst == r) || (mem.v && mem.dst == r) || wb_hit);
  endfunction

  // NOTE: every output gets a default before the branches below, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_flush_o  = 1'b0;
    exmem_flush_o = 1'b0;
    stall_o       = 1'b0;
    raw = (id_use_rs_i && hit(id_rs_i, ex_q, mem_q, wb_q)) ||
          (id_use_rt_i && hit(id_rt_i, ex_q, mem_q, wb_q));
    if (rst_i) begin
      if (branch_taken_mem_i) begin
        ifid_flush_o  = 1'b1;
        idex_flush_o  = 1'b1;
        exmem_flush_o = 1'b1;
      end else if (raw) begin
        pc_write_o   = 1'b0;
        ifid_write_o = 1'b0;
        idex_flush_o = 1'b1;
        stall_o      = 1'b1;
      end
    end
  end

  always_comb begin
    ex_d  = idex_flush_o ? '0 : slot_t'{id_reg_write_i && (id_dst_i != '0), id_dst_i};
    mem_d = exmem_flush_o ? '0 : ex_q;
  end

  // NOTE: state registers use non-blocking assignments so every slot shifts from its pre-edge value.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= mem_q;
      if (stall_o && (stall_cnt_o != '1))
        stall_cnt_o <= stall_cnt_o + 1'b1;
      if (branch_taken_mem_i && (flush_cnt_o != '1))
        flush_cnt_o <= flush_cnt_o + 1'b1;
    end
  end

endmodule
